key_conditioner: RTL and testbench



---
 rtl/key_conditioner_if.sv | 12 +
 rtl/key_conditioner.sv | 162 ++++++++++++++++
 tb/tb_key_conditioner.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw key pins in, debounced level and press/release pulses out.
interface key_conditioner_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (output key_in, input key_level, input key_press, input key_release);
  modport slave  (input key_in, output key_level, output key_press, output key_release);
endinterface

// File: rtl/key_conditioner.sv
// Per-key 2-flop synchronizer, polarity normalisation and debounce FSM with press/release pulses.
// Optional auto-repeat of key_press while a key is held: define KEY_AUTOREPEAT_EN.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int RPT_W           = 25
) (
  input logic              clk,
  input logic              reset,
  key_conditioner_if.slave bus
);
  // state    | meaning
  // IDLE     | released, waiting for p = 1
  // PRESS_DB | p = 1 seen, counting stable cycles before accepting the press
  // PRESSED  | press accepted, key_level = 1
  // REL_DB   | p = 0 seen, counting stable cycles before accepting the release
  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_e;

  localparam logic             REL_LVL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
  logic [NUM_KEYS-1:0] key_p;
  state_e              state_q [NUM_KEYS];
  state_e              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  // rpt_arm marks that the initial delay has elapsed and the period now applies.
  logic [RPT_W-1:0]    rpt_q [NUM_KEYS];
  logic [RPT_W-1:0]    rpt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] rpt_arm_q, rpt_arm_d;
`else
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || RPT_W < 1) begin : g_no_repeat
  end
`endif

  assign key_p           = REL_LVL ? ~sync2_q : sync2_q;
  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;

  always_comb begin
    sync1_d   = bus.key_in;
    sync2_d   = sync1_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
`ifdef KEY_AUTOREPEAT_EN
    rpt_d     = rpt_q;
    rpt_arm_d = rpt_arm_q;
`endif
    for (int k = 0; k < NUM_KEYS; k++) begin
      case (state_q[k])
        IDLE: begin
          level_d[k] = 1'b0;
          if (key_p[k]) begin
            state_d[k] = PRESS_DB;
            cnt_d[k]   = '0;
          end
        end
        PRESS_DB: begin
          if (!key_p[k]) begin
            state_d[k] = IDLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == DB_LAST) begin
            state_d[k] = PRESSED;
            cnt_d[k]   = '0;
            level_d[k] = 1'b1;
            press_d[k] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rpt_d[k]     = '0;
            rpt_arm_d[k] = 1'b0;
`endif
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        PRESSED: begin
          level_d[k] = 1'b1;
          if (!key_p[k]) begin
            state_d[k] = REL_DB;
            cnt_d[k]   = '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (rpt_q[k] == (rpt_arm_q[k] ? RPT_NEXT : RPT_FIRST)) begin
            press_d[k]   = 1'b1;
            rpt_d[k]     = '0;
            rpt_arm_d[k] = 1'b1;
          end else begin
            rpt_d[k] = rpt_q[k] + 1'b1;
          end
`endif
        end
        REL_DB: begin
          if (key_p[k]) begin
            state_d[k] = PRESSED;
            cnt_d[k]   = '0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_d[k]     = '0;
            rpt_arm_d[k] = 1'b0;
`endif
          end else if (cnt_q[k] == DB_LAST) begin
            state_d[k]   = IDLE;
            cnt_d[k]     = '0;
            level_d[k]   = 1'b0;
            release_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        default: begin
          state_d[k] = IDLE;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= {NUM_KEYS{REL_LVL}};
      sync2_q   <= {NUM_KEYS{REL_LVL}};
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_q[k]   <= '0;
`endif
      end
`ifdef KEY_AUTOREPEAT_EN
      rpt_arm_q <= '0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
`ifdef KEY_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
      rpt_arm_q <= rpt_arm_d;
`endif
    end
  end
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed vector table, corner sequences and random keys vs a run-length model.
module tb_key_conditioner;
  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  typedef struct {
    logic [NK-1:0] keys;
    int            ncyc;
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rls;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  key_conditioner_if #(.NUM_KEYS(NK)) bus ();

  key_conditioner #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB), .CNT_W(4),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .RPT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: pins reach the FSM two edges late; a level flips once the delayed
  // pressed value has differed from it on DB+1 consecutive edges.
  logic [NK-1:0] m_d1, m_d2, m_level, m_press, m_rel;
  int            m_run  [NK];
  int            m_held [NK];

  function automatic void model_reset();
    m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0;
    for (int k = 0; k < NK; k++) begin
      m_run[k] = 0; m_held[k] = 0;
    end
  endfunction

  function automatic void model_step(input logic [NK-1:0] pins);
    logic [NK-1:0] p;
    p = m_d2; m_d2 = m_d1; m_d1 = ~pins;
    m_press = '0; m_rel = '0;
    for (int k = 0; k < NK; k++) begin
      if (p[k] != m_level[k]) begin
        m_run[k]++;
        if (m_run[k] == DB + 1) begin
          m_level[k] = p[k];
          m_run[k]   = 0;
          m_held[k]  = 0;
          if (p[k]) m_press[k] = 1'b1;
          else      m_rel[k]   = 1'b1;
        end
      end else begin
        if (m_level[k]) begin
          if (m_run[k] != 0) m_held[k] = 0;
          else begin
            m_held[k]++;
`ifdef KEY_AUTOREPEAT_EN
            if (m_held[k] >= RD && (m_held[k] - RD) % RP == 0) m_press[k] = 1'b1;
`endif
          end
        end
        m_run[k] = 0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step(bus.key_in);
    #1;
    check("outputs", {bus.key_level, bus.key_press, bus.key_release}, {m_level, m_press, m_rel});
  endtask

  task automatic async_reset();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_async", {bus.key_level, bus.key_press, bus.key_release}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t tbl [11];
  int   pc [NK];
  int   rc [NK];
  int   exp_p [$];
  int   got_p [$];
  int   got_r [$];

  initial begin
    int            first;
    int            n;
    logic [NK-1:0] keys;

    tbl[0]  = '{4'hF, 20, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'hD, 10, 4'h2, 4'h2, 4'h0};
    tbl[2]  = '{4'hF, 10, 4'h0, 4'h0, 4'h2};
    tbl[3]  = '{4'hE,  3, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'hF, 10, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{4'hB, 10, 4'h4, 4'h4, 4'h0};
    tbl[6]  = '{4'hF,  2, 4'h4, 4'h0, 4'h0};
    tbl[7]  = '{4'hB,  8, 4'h4, 4'h0, 4'h0};
    tbl[8]  = '{4'hF, 10, 4'h0, 4'h0, 4'h4};
    tbl[9]  = '{4'h9, 10, 4'h6, 4'h6, 4'h0};
    tbl[10] = '{4'hF, 10, 4'h0, 4'h0, 4'h6};

    bus.key_in = 4'hF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {bus.key_level, bus.key_press, bus.key_release}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < NK; k++) begin pc[k] = 0; rc[k] = 0; end
      bus.key_in = tbl[i].keys;
      for (int c = 0; c < tbl[i].ncyc; c++) begin
        step_cycle();
        for (int k = 0; k < NK; k++) begin
          pc[k] += int'(bus.key_press[k]);
          rc[k] += int'(bus.key_release[k]);
        end
      end
      check($sformatf("tbl%0d_level", i), bus.key_level, tbl[i].lvl);
      for (int k = 0; k < NK; k++) begin
        check($sformatf("tbl%0d_press%0d", i, k), pc[k], tbl[i].prs[k]);
        check($sformatf("tbl%0d_rel%0d", i, k), rc[k], tbl[i].rls[k]);
      end
    end

    // Reset while key3 is pressed, key still held: fresh full debounce.
    bus.key_in = 4'h7;
    repeat (10) step_cycle();
    check("k3_held_level", bus.key_level, 4'h8);
    async_reset();
    first = -1; n = 0;
    for (int e = 0; e < 10; e++) begin
      step_cycle();
      if (bus.key_press[3]) begin
        if (first < 0) first = e;
        n++;
      end
    end
    check("k3_repress_edge", first, 6);
    check("k3_repress_cnt", n, 1);
    bus.key_in = 4'hF;
    repeat (10) step_cycle();

    // Reset in the middle of PRESS_DB on key0, key still held.
    bus.key_in = 4'hE;
    repeat (4) step_cycle();
    async_reset();
    first = -1; n = 0;
    for (int e = 0; e < 10; e++) begin
      step_cycle();
      if (bus.key_press[0]) begin
        if (first < 0) first = e;
        n++;
      end
    end
    check("k0_redb_edge", first, 6);
    check("k0_redb_cnt", n, 1);
    bus.key_in = 4'hF;
    repeat (10) step_cycle();

    // Long hold on key1: acceptance pulse, plus repeats when enabled.
    exp_p.push_back(6);
`ifdef KEY_AUTOREPEAT_EN
    for (int e = 6 + RD; e <= 38; e += RP) exp_p.push_back(e);
`endif
    bus.key_in = 4'hD;
    for (int e = 0; e < 50; e++) begin
      if (e == 37) bus.key_in = 4'hF;
      step_cycle();
      if (bus.key_press[1])   got_p.push_back(e);
      if (bus.key_release[1]) got_r.push_back(e);
    end
    check("hold_press_cnt", got_p.size(), exp_p.size());
    for (int i = 0; i < got_p.size() && i < exp_p.size(); i++)
      check($sformatf("hold_press_edge%0d", i), got_p[i], exp_p[i]);
    check("hold_rel_cnt", got_r.size(), 1);
    if (got_r.size() > 0) check("hold_rel_edge", got_r[0], 43);

    // Random key activity with one asynchronous reset in the middle.
    keys = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, NK - 1);
        keys[n] = ~keys[n];
      end
      bus.key_in = keys;
      step_cycle();
      if (i == 1500) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
